// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory initiator for the multicycle core.
// IDLE -> ISSUE -> WAIT -> RESP FSM on a req/gnt/rvalid port, with byte-lane steering
// for stores and extraction plus sign/zero extension for loads.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word accesses
// with an error response and no memory access.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // counter just wide enough to hold TIMEOUT
  localparam int          CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic          op_we;
  logic [2:0]    op_f3;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [CW-1:0] cnt;

  logic          f3_ok, misalign, reject, timeout;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   load_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // request screening on the incoming (not yet latched) request
  assign f3_ok = req_we_i ? (req_funct3_i <= F3_W)
                          : (req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign reject  = !f3_ok || misalign;

  // timeout fires on the TIMEOUT-th WAIT cycle; rvalid in the same cycle wins
  assign timeout = (TIMEOUT != 0) && (cnt == TO_VAL);

  // store lane steering and load extraction from the latched op
  always_comb begin
    be        = 4'b1111;
    wdata_rep = op_wdata;
    if (op_we) begin
      case (op_f3[1:0])
        2'b00:   begin be = 4'b0001 << op_addr[1:0];         wdata_rep = {4{op_wdata[7:0]}};  end
        2'b01:   begin be = 4'b0011 << {op_addr[1], 1'b0};   wdata_rep = {2{op_wdata[15:0]}}; end
        default: begin be = 4'b1111;                         wdata_rep = op_wdata;            end
      endcase
    end
    ld_byte = 8'(mem_rdata_i >> {op_addr[1:0], 3'b000});
    ld_half = op_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_f3)
      F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_ext = {24'd0, ld_byte};
      F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_ext = {16'd0, ld_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  // next state and outputs; memory-side signals are only driven while in ISSUE
  always_comb begin
    state_d     = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = reject ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = op_we;
        mem_be_o    = be;
        mem_addr_o  = {op_addr[31:2], 2'b00};
        mem_wdata_o = wdata_rep;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rsp_data;
        rsp_err_o   = rsp_err;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // op latch, watchdog counter and response capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_we    <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          op_we    <= req_we_i;
          op_f3    <= req_funct3_i;
          op_addr  <= req_addr_i;
          op_wdata <= req_wdata_i;
          rsp_data <= '0;
          rsp_err  <= reject;
          cnt      <= '0;
        end
        ISSUE: if (mem_gnt_i) cnt <= CW'(1);
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid_i)  rsp_data <= op_we ? '0 : load_ext;
          else if (timeout)  rsp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, load extension, latency,
// gnt backpressure, watchdog timeout, illegal/misaligned requests, mid-op reset.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // captured results of the last access
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_err, r_we, r_req_seen;
  bit          r_stable;
  int          r_lat;

  // one request with a scripted memory: gnt after gnt_dly ISSUE cycles, rvalid the cycle after gnt
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_dly, input bit give_rvalid);
    int  held = 0;
    bit  granted = 0;
    bit  got = 0;
    r_rdata = '0; r_err = 1'b0; r_lat = 0; r_req_seen = 1'b0; r_stable = 1;
    r_addr = '0; r_be = '0; r_wdata = '0; r_we = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd; mem_rdata_i = rd;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = granted && give_rvalid;
      granted = 0;
      if (rsp_valid_o) begin
        got = 1; r_lat = c; r_rdata = rsp_rdata_o; r_err = rsp_err_o;
      end else if (mem_req_o) begin
        if (!r_req_seen) begin
          r_req_seen = 1'b1; r_addr = mem_addr_o; r_be = mem_be_o;
          r_wdata = mem_wdata_o; r_we = mem_we_o;
        end else if (mem_addr_o !== r_addr || mem_be_o !== r_be ||
                     mem_wdata_o !== r_wdata || mem_we_o !== r_we) begin
          r_stable = 0;
        end
        if (held < gnt_dly) held++;
        else begin mem_gnt_i = 1'b1; granted = 1; end
      end
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    if (!got) chk("rsp_never_arrived", 32'd0, 32'd1);
    else begin
      @(negedge clk_i);
      chk("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ready",  32'(req_ready_o), 32'd1);
    chk("rst_rspv",   32'(rsp_valid_o), 32'd0);
    chk("rst_rdata",  rsp_rdata_o, 32'd0);
    chk("rst_err",    32'(rsp_err_o), 32'd0);
    chk("rst_memreq", 32'(mem_req_o), 32'd0);
    chk("rst_we",     32'(mem_we_o), 32'd0);
    chk("rst_be",     32'(mem_be_o), 32'd0);
    chk("rst_addr",   mem_addr_o, 32'd0);
    chk("rst_wdata",  mem_wdata_o, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // SB lane steering
    access(1'b1, 3'b000, 32'h102, 32'h123456A5, 32'hDEADBEEF, 0, 1);
    chk("sb_be", 32'(r_be), 32'h4);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
    chk("sb_addr", r_addr, 32'h100);
    chk("sb_we", 32'(r_we), 32'd1);
    chk("sb_err", 32'(r_err), 32'd0);
    chk("sb_rdata", r_rdata, 32'd0);
    // SH upper half, SW
    access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0, 1);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
    access(1'b1, 3'b010, 32'h104, 32'h12345678, 32'h0, 0, 1);
    chk("sw_be", 32'(r_be), 32'hF);
    chk("sw_wdata", r_wdata, 32'h12345678);
    chk("sw_addr", r_addr, 32'h104);

    // byte loads, minimum latency
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);
    chk("lb_lat", 32'(r_lat), 32'd3);
    chk("lb_be", 32'(r_be), 32'hF);
    chk("lb_we", 32'(r_we), 32'd0);
    chk("lb_addr", r_addr, 32'h100);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1);
    chk("lbu_rdata", r_rdata, 32'h00000080);
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0, 1);
    chk("lb1_rdata", r_rdata, 32'h00000012);

    // half and word loads
    access(1'b0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 1);
    chk("lh_rdata", r_rdata, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h202, 32'h0, 32'h80017FFF, 0, 1);
    chk("lhu_rdata", r_rdata, 32'h00008001);
    access(1'b0, 3'b001, 32'h200, 32'h0, 32'h80017FFF, 0, 1);
    chk("lh_lo_rdata", r_rdata, 32'h00007FFF);
    access(1'b0, 3'b010, 32'h200, 32'h0, 32'h80017FFF, 0, 1);
    chk("lw_rdata", r_rdata, 32'h80017FFF);
    chk("lw_err", 32'(r_err), 32'd0);

    // gnt held off 5 cycles, then no rvalid: watchdog after 64 WAIT cycles
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 5, 0);
    chk("to_stable", 32'(r_stable), 32'd1);
    chk("to_addr", r_addr, 32'h400);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_rdata", r_rdata, 32'd0);
    chk("to_lat", 32'(r_lat), 32'd71);
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("late_rvalid_rspv", 32'(rsp_valid_o), 32'd0);
    chk("late_rvalid_ready", 32'(req_ready_o), 32'd1);
    access(1'b0, 3'b010, 32'h404, 32'h0, 32'h22223333, 1, 1);
    chk("after_to_rdata", r_rdata, 32'h22223333);
    chk("after_to_err", 32'(r_err), 32'd0);

    // misaligned word
    access(1'b0, 3'b010, 32'h301, 32'h0, 32'hCAFEF00D, 0, 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", 32'(r_err), 32'd1);
    chk("mis_noreq", 32'(r_req_seen), 32'd0);
    chk("mis_rdata", r_rdata, 32'd0);
    chk("mis_lat", 32'(r_lat), 32'd1);
`else
    chk("mis_err", 32'(r_err), 32'd0);
    chk("mis_addr", r_addr, 32'h300);
    chk("mis_rdata", r_rdata, 32'hCAFEF00D);
`endif
    // illegal funct3
    access(1'b0, 3'b011, 32'h300, 32'h0, 32'hCAFEF00D, 0, 1);
    chk("ill_ld_err", 32'(r_err), 32'd1);
    chk("ill_ld_noreq", 32'(r_req_seen), 32'd0);
    chk("ill_ld_rdata", r_rdata, 32'd0);
    chk("ill_ld_lat", 32'(r_lat), 32'd1);
    access(1'b1, 3'b011, 32'h300, 32'h0, 32'h0, 0, 1);
    chk("ill_st_err", 32'(r_err), 32'd1);
    chk("ill_st_noreq", 32'(r_req_seen), 32'd0);

    // reset while in WAIT; a late rvalid must not produce a response
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h500;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rr_issue_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("rr_wait_noreq", 32'(mem_req_o), 32'd0);
    chk("rr_wait_busy", 32'(req_ready_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rr_ready", 32'(req_ready_o), 32'd1);
    chk("rr_memreq", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk("rr_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    access(1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 0, 1);
    chk("rr_next_rdata", r_rdata, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
